// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage register: upstream beat, downstream beat, flush and fill level.
// master = the surrounding pipeline, slave = the stage register itself.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned CTRL_W = 12
);
    logic              In_valid;
    logic              In_ready;
    logic [DATA_W-1:0] In_data;
    logic [CTRL_W-1:0] In_ctrl;
    logic              Flush;
    logic              Out_valid;
    logic              Out_ready;
    logic [DATA_W-1:0] Out_data;
    logic [CTRL_W-1:0] Out_ctrl;
    logic [1:0]        Occupancy;

    modport master (
        output In_valid, In_data, In_ctrl, Flush, Out_ready,
        input  In_ready, Out_valid, Out_data, Out_ctrl, Occupancy
    );

    modport slave (
        input  In_valid, In_data, In_ctrl, Flush, Out_ready,
        output In_ready, Out_valid, Out_data, Out_ctrl, Occupancy
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a 2-entry skid buffer, synchronous flush and bubble gating of control bits.
// All state lives in one register bundle clocked on the edge chosen by NEG_EDGE.
module pipe_stage_reg #(
    parameter int unsigned DATA_W   = 128,
    parameter int unsigned CTRL_W   = 12,
    parameter bit          NEG_EDGE = 1'b1
) (
    input logic            Clk,
    input logic            Rst_n,
    pipe_stage_reg_if.slave bus
);
    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        state_t            st;
        logic [DATA_W-1:0] hd;
        logic [CTRL_W-1:0] hc;
        logic [DATA_W-1:0] sd;
        logic [CTRL_W-1:0] sc;
    } regs_t;

    regs_t r_q;
    regs_t w_nxt;
    logic  w_in_ready;
    logic  w_out_valid;
    logic  w_accept;
    logic  w_pop;

    assign w_in_ready  = (r_q.st != TWO);
    assign w_out_valid = (r_q.st != EMPTY);
    assign w_accept    = bus.In_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.Out_ready;

    // Entries load only on accept, so garbage on In_* while In_valid=0 never lands in storage.
    always_comb begin
        w_nxt = r_q;
        if (bus.Flush) begin
            w_nxt.st = EMPTY;
        end else begin
            unique case (r_q.st)
                EMPTY: begin
                    if (w_accept) begin
                        w_nxt.st = ONE;
                        w_nxt.hd = bus.In_data;
                        w_nxt.hc = bus.In_ctrl;
                    end
                end
                ONE: begin
                    if (w_accept && w_pop) begin
                        w_nxt.hd = bus.In_data;
                        w_nxt.hc = bus.In_ctrl;
                    end else if (w_accept) begin
                        w_nxt.st = TWO;
                        w_nxt.sd = bus.In_data;
                        w_nxt.sc = bus.In_ctrl;
                    end else if (w_pop) begin
                        w_nxt.st = EMPTY;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_nxt.st = ONE;
                        w_nxt.hd = r_q.sd;
                        w_nxt.hc = r_q.sc;
                    end
                end
                default: w_nxt.st = EMPTY;
            endcase
        end
    end

    if (NEG_EDGE) begin : g_neg
        always_ff @(negedge Clk or negedge Rst_n) begin
            if (!Rst_n) r_q <= '0;
            else        r_q <= w_nxt;
        end
    end else begin : g_pos
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) r_q <= '0;
            else        r_q <= w_nxt;
        end
    end

    // In_ready is a pure function of the state register, so it never sees Out_ready combinationally.
    assign bus.In_ready  = w_in_ready;
    assign bus.Out_valid = w_out_valid;
    assign bus.Out_data  = r_q.hd;
    assign bus.Out_ctrl  = r_q.hc & {CTRL_W{w_out_valid}};
    assign bus.Occupancy = r_q.st;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: one rising-edge and one falling-edge instance share identical stimulus;
// each table row spans one full clock period so both instances update exactly once per row.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef struct {
        bit          iv;
        logic [DW-1:0] din;
        logic [CW-1:0] cin;
        bit          fl;
        bit          ordy;
        bit          ev;
        bit          er;
        logic [DW-1:0] ed;
        bit          cd;
        logic [CW-1:0] ec;
        logic [1:0]  eo;
    } rec_t;

    logic Clk;
    logic Rst_n;
    int   total;
    int   bad;
    rec_t vec[$];

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) p_if ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) n_if ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NEG_EDGE(1'b0)) u_pos (
        .Clk(Clk), .Rst_n(Rst_n), .bus(p_if)
    );
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .NEG_EDGE(1'b1)) u_neg (
        .Clk(Clk), .Rst_n(Rst_n), .bus(n_if)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input bit iv, input logic [DW-1:0] din, input logic [CW-1:0] cin,
                                input bit fl, input bit ordy, input bit ev, input bit er,
                                input logic [DW-1:0] ed, input bit cd, input logic [CW-1:0] ec,
                                input logic [1:0] eo);
        rec_t r;
        r.iv = iv; r.din = din; r.cin = cin; r.fl = fl; r.ordy = ordy;
        r.ev = ev; r.er = er; r.ed = ed; r.cd = cd; r.ec = ec; r.eo = eo;
        vec.push_back(r);
    endfunction

    task automatic drive(input rec_t r);
        p_if.In_valid = r.iv;  n_if.In_valid = r.iv;
        p_if.In_data  = r.din; n_if.In_data  = r.din;
        p_if.In_ctrl  = r.cin; n_if.In_ctrl  = r.cin;
        p_if.Flush    = r.fl;  n_if.Flush    = r.fl;
        p_if.Out_ready = r.ordy; n_if.Out_ready = r.ordy;
    endtask

    task automatic chk_pos(input string tag, input rec_t e, input bit full);
        chk({tag, " p ov"}, 32'(p_if.Out_valid), 32'(e.ev));
        chk({tag, " p occ"}, 32'(p_if.Occupancy), 32'(e.eo));
        if (e.cd) chk({tag, " p data"}, 32'(p_if.Out_data), 32'(e.ed));
        if (full) begin
            chk({tag, " p rdy"}, 32'(p_if.In_ready), 32'(e.er));
            chk({tag, " p ctrl"}, 32'(p_if.Out_ctrl), 32'(e.ec));
        end
    endtask

    task automatic chk_neg(input string tag, input rec_t e, input bit full);
        chk({tag, " n ov"}, 32'(n_if.Out_valid), 32'(e.ev));
        chk({tag, " n occ"}, 32'(n_if.Occupancy), 32'(e.eo));
        if (e.cd) chk({tag, " n data"}, 32'(n_if.Out_data), 32'(e.ed));
        if (full) begin
            chk({tag, " n rdy"}, 32'(n_if.In_ready), 32'(e.er));
            chk({tag, " n ctrl"}, 32'(n_if.Out_ctrl), 32'(e.ec));
        end
    endtask

    // Between the rising and falling edge only the rising-edge instance may have moved.
    task automatic step(input string tag, input rec_t r, input rec_t prev);
        drive(r);
        @(posedge Clk); #1;
        chk_pos({tag, " mid"}, r, 1'b0);
        chk_neg({tag, " mid"}, prev, 1'b0);
        @(negedge Clk); #1;
        chk_pos(tag, r, 1'b1);
        chk_neg(tag, r, 1'b1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " p ov"},   32'(p_if.Out_valid), 32'd0);
        chk({tag, " p data"}, 32'(p_if.Out_data),  32'd0);
        chk({tag, " p ctrl"}, 32'(p_if.Out_ctrl),  32'd0);
        chk({tag, " p occ"},  32'(p_if.Occupancy), 32'd0);
        chk({tag, " p rdy"},  32'(p_if.In_ready),  32'd1);
        chk({tag, " n ov"},   32'(n_if.Out_valid), 32'd0);
        chk({tag, " n data"}, 32'(n_if.Out_data),  32'd0);
        chk({tag, " n ctrl"}, 32'(n_if.Out_ctrl),  32'd0);
        chk({tag, " n occ"},  32'(n_if.Occupancy), 32'd0);
        chk({tag, " n rdy"},  32'(n_if.In_ready),  32'd1);
    endtask

    initial begin
        rec_t rst_rec;
        rec_t prev;
        total = 0;
        bad   = 0;

        //   iv din       cin  fl ordy  ev er ed        cd ec   eo
        for (int i = 1; i <= 10; i++)
            add(1, DW'(i), CW'(i), 0, 1,  1, 1, DW'(i), 1, CW'(i), 2'd1);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,   0, 4'h0, 2'd0);
        // backpressure fill, offered-but-refused beat while full, then drain
        add(1, 16'h00AA, 4'h1, 0, 0,  1, 1, 16'h00AA, 1, 4'h1, 2'd1);
        add(1, 16'h00BB, 4'h2, 0, 0,  1, 0, 16'h00AA, 1, 4'h1, 2'd2);
        for (int i = 0; i < 5; i++)
            add(1, 16'h00EE, 4'h3, 0, 0,  1, 0, 16'h00AA, 1, 4'h1, 2'd2);
        add(0, 16'hDEAD, 4'hF, 0, 1,  1, 1, 16'h00BB, 1, 4'h2, 2'd1);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        // flush while full with a simultaneous offer and pop
        add(1, 16'h0011, 4'h5, 0, 0,  1, 1, 16'h0011, 1, 4'h5, 2'd1);
        add(1, 16'h0022, 4'h6, 0, 0,  1, 0, 16'h0011, 1, 4'h5, 2'd2);
        add(1, 16'h00CC, 4'h7, 1, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        // flush while holding one beat with a simultaneous offer
        add(1, 16'h0033, 4'h1, 0, 0,  1, 1, 16'h0033, 1, 4'h1, 2'd1);
        add(1, 16'h0044, 4'h2, 1, 0,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        add(0, 16'hDEAD, 4'hF, 0, 0,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        // bubble gating: all-ones control visible only while valid
        add(1, 16'h0055, 4'hF, 0, 0,  1, 1, 16'h0055, 1, 4'hF, 2'd1);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        // FIFO order through the skid entry, then accept-and-pop in ONE
        add(1, 16'h0061, 4'h1, 0, 0,  1, 1, 16'h0061, 1, 4'h1, 2'd1);
        add(1, 16'h0062, 4'h2, 0, 0,  1, 0, 16'h0061, 1, 4'h1, 2'd2);
        add(1, 16'h0063, 4'h3, 0, 1,  1, 1, 16'h0062, 1, 4'h2, 2'd1);
        add(1, 16'h0063, 4'h3, 0, 1,  1, 1, 16'h0063, 1, 4'h3, 2'd1);
        add(0, 16'hDEAD, 4'hF, 0, 1,  0, 1, 16'h0,    0, 4'h0, 2'd0);
        // leave a valid beat held for the asynchronous reset check
        add(1, 16'h0077, 4'h9, 0, 0,  1, 1, 16'h0077, 1, 4'h9, 2'd1);

        rst_rec = '{iv:0, din:16'h0, cin:4'h0, fl:0, ordy:0,
                    ev:0, er:1, ed:16'h0, cd:1, ec:4'h0, eo:2'd0};

        Rst_n = 1'b0;
        drive(rst_rec);
        #1;
        chk_reset("por");
        #20;                       // t=21, just after a falling edge
        Rst_n = 1'b1;

        prev = rst_rec;
        foreach (vec[i]) begin
            step($sformatf("r%0d", i), vec[i], prev);
            prev = vec[i];
        end

        // Asynchronous reset mid-cycle with HEAD valid: must act before any edge.
        #2;
        Rst_n = 1'b0;
        #1;
        chk_reset("arst");
        drive('{iv:1, din:16'h0099, cin:4'hF, fl:0, ordy:1,
                ev:0, er:1, ed:16'h0, cd:1, ec:4'h0, eo:2'd0});
        #10;
        chk_reset("arst hold");
        @(negedge Clk); #1;
        Rst_n = 1'b1;
        step("post", '{iv:1, din:16'h0088, cin:4'h2, fl:0, ordy:1,
                       ev:1, er:1, ed:16'h0088, cd:1, ec:4'h2, eo:2'd1}, rst_rec);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
